// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, round constants, S-box and rotation amounts for the Ascon permutation
package ascon_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  // x0 occupies the top 64 bits so a flat 320-bit view reads x0..x4 left to right
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam int NUM_RC = 12;

  localparam logic [7:0] RC [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  // 5-bit column substitution; bit 4 of the index/result is the x0 bit
  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'd0:  r = 5'h04;
      5'd1:  r = 5'h0b;
      5'd2:  r = 5'h1f;
      5'd3:  r = 5'h14;
      5'd4:  r = 5'h1a;
      5'd5:  r = 5'h15;
      5'd6:  r = 5'h09;
      5'd7:  r = 5'h02;
      5'd8:  r = 5'h1b;
      5'd9:  r = 5'h05;
      5'd10: r = 5'h08;
      5'd11: r = 5'h12;
      5'd12: r = 5'h1d;
      5'd13: r = 5'h03;
      5'd14: r = 5'h06;
      5'd15: r = 5'h1c;
      5'd16: r = 5'h1e;
      5'd17: r = 5'h13;
      5'd18: r = 5'h07;
      5'd19: r = 5'h0e;
      5'd20: r = 5'h00;
      5'd21: r = 5'h0d;
      5'd22: r = 5'h11;
      5'd23: r = 5'h18;
      5'd24: r = 5'h10;
      5'd25: r = 5'h0c;
      5'd26: r = 5'h01;
      5'd27: r = 5'h19;
      5'd28: r = 5'h16;
      5'd29: r = 5'h0a;
      5'd30: r = 5'h0f;
      5'd31: r = 5'h17;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Indices past the table (the counter parks at 12 after the last round) yield zero
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < NUM_RC; i++) begin
      if (idx == 4'(i)) c = RC[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant addition, S-box layer, linear diffusion
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_in,
  input  logic [7:0]   rc,
  output ascon_state_t state_out
);

  ascon_state_t added;
  ascon_state_t subst;

  // round constant lands in the low byte of x2
  always_comb begin
    added    = state_in;
    added.x2 = state_in.x2 ^ {56'd0, rc};
  end

  // S-box applied independently to each of the 64 bit columns
  always_comb begin
    subst = '0;
    for (int i = 0; i < 64; i++) begin
      {subst.x0[i], subst.x1[i], subst.x2[i], subst.x3[i], subst.x4[i]} =
        sbox({added.x0[i], added.x1[i], added.x2[i], added.x3[i], added.x4[i]});
    end
  end

  // per-word diffusion: word xor two rotations of itself
  always_comb begin
    state_out.x0 = subst.x0 ^ ror64(subst.x0, ROT_X0_A) ^ ror64(subst.x0, ROT_X0_B);
    state_out.x1 = subst.x1 ^ ror64(subst.x1, ROT_X1_A) ^ ror64(subst.x1, ROT_X1_B);
    state_out.x2 = subst.x2 ^ ror64(subst.x2, ROT_X2_A) ^ ror64(subst.x2, ROT_X2_B);
    state_out.x3 = subst.x3 ^ ror64(subst.x3, ROT_X3_A) ^ ror64(subst.x3, ROT_X3_B);
    state_out.x4 = subst.x4 ^ ror64(subst.x4, ROT_X4_A) ^ ror64(subst.x4, ROT_X4_B);
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - iterative p^N sequencer holding the 320-bit state, one round per clock
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      rounds,
  input  logic [BITS-1:0] x0_in,
  input  logic [BITS-1:0] x1_in,
  input  logic [BITS-1:0] x2_in,
  input  logic [BITS-1:0] x3_in,
  input  logic [BITS-1:0] x4_in,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] x0_out,
  output logic [BITS-1:0] x1_out,
  output logic [BITS-1:0] x2_out,
  output logic [BITS-1:0] x3_out,
  output logic [BITS-1:0] x4_out
);

  fsm_state_t   state;
  fsm_state_t   next_state;
  ascon_state_t st_q;
  ascon_state_t st_round;
  logic [3:0]   rc_idx;
  logic [3:0]   n_eff;
  logic [7:0]   rc_cur;
  logic         load;
  logic         step;
  logic         last;

  // out-of-range round counts fall back to the full 12-round permutation
  assign n_eff  = (rounds == 4'd0 || rounds > 4'd12) ? 4'd12 : rounds;
  assign rc_cur = round_const(rc_idx);

  ascon_round u_round (
    .state_in  (st_q),
    .rc        (rc_cur),
    .state_out (st_round)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // next-state and control decode; the final round is the one using the last table constant
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (rc_idx == 4'd11) begin
          last       = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // state register, round-constant counter and registered done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= '0;
      rc_idx <= 4'd0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        st_q   <= {x0_in, x1_in, x2_in, x3_in, x4_in};
        rc_idx <= 4'd12 - n_eff;
      end else if (step) begin
        st_q   <= st_round;
        rc_idx <= rc_idx + 4'd1;
      end
    end
  end

  assign x0_out = st_q.x0;
  assign x1_out = st_q.x1;
  assign x2_out = st_q.x2;
  assign x3_out = st_q.x3;
  assign x4_out = st_q.x4;

endmodule

// File: doc/ascon_perm_ctrl.md
# ascon_perm_ctrl

Iterative sequencer for the Ascon permutation p^N over the 320-bit state (five 64-bit words x0..x4). It holds the state in a register and applies one round per clock: constant addition, S-box layer, then linear diffusion. It sits between the AEAD/hash mode controller, which loads, absorbs and squeezes the state, and the combinational round datapath. It supports p^12, p^8, p^6 and any round count from 1 to 12.

## Interface
- Parameters
  - `BITS`, default 64: word width. Only 64 is supported.
- Ports
  - `clk`, input, 1: single clock. All state updates occur on its rising edge.
  - `rst`, input, 1: reset. Synchronous and active-high.
  - `start`, input, 1: request a permutation. Sampled only while idle.
  - `rounds`, input, 4: round count N, sampled with `start`. 0 or values above 12 are treated as 12.
  - `x0_in` … `x4_in`, input, 64 each: initial state, sampled with `start`.
  - `busy`, output, 1: high while rounds are executing.
  - `done`, output, 1: one-cycle pulse when the result is valid.
  - `x0_out` … `x4_out`, output, 64 each: state register contents.

## Operation
- FSM has two states.
  - IDLE: `busy`=0. If `start`=1, load the state register from `x*_in`, set `rc_idx` = 12−N (4-bit), and go to RUN.
  - RUN: `busy`=1. Each cycle, the state becomes round(state, RC[rc_idx]) and `rc_idx` increments. When `rc_idx`=11, the FSM returns to IDLE and `done` is registered high for the next cycle.
- Round constants: RC[i] = {0xf0, 0xe1, 0xd2, 0xc3, 0xb4, 0xa5, 0x96, 0x87, 0x78, 0x69, 0x5a, 0x4b}. The constant is XORed into the low byte of x2.
- S-box: the standard Ascon 5-bit S-box applied per bit column, with x0 as the MSB.
- Linear diffusion uses 64-bit rotations, not logical shifts. Rotation amounts:
  - x0: 19, 28
  - x1: 61, 39
  - x2: 1, 6
  - x3: 10, 17
  - x4: 7, 41
- `start` is ignored while in RUN. No queuing and no error flag.
- `start` in the same cycle that `done` is high is accepted. This gives back-to-back permutations with no gap.
- `x*_out` always shows the state register. It is valid when `done`=1 and holds until the next accepted `start`.
- `rounds` and `x*_in` are don't-care except in the cycle where `start` is accepted.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, state register=0 (all `x*_out`=0), `rc_idx`=0.
- Let `start` be sampled in cycle 0.
  - `busy` is high in cycles 1..N.
  - Round k is applied at the end of cycle k.
  - `done`=1 and `busy`=0 in cycle N+1.
  - Total latency from start to result is N+1 cycles.
  - Throughput is one permutation per N+1 cycles.
- `rst` takes priority over everything. If asserted mid-RUN, the current operation is abandoned and the next cycle shows reset values. No `done` is issued for the abandoned operation.
- `done` never stays high for two consecutive cycles.

## Structure
- Package `ascon_pkg` holds:
  - the FSM state enum
  - `RC` constant array [0:11] of 8-bit values
  - S-box lookup function
  - rotation-amount localparams
  - `ascon_state_t`, a struct of five 64-bit words
- One sub-module, `ascon_round`: combinational, 320-bit state in, 8-bit constant in, 320-bit state out.
- The controller (FSM, counter and state register) lives in `ascon_perm_ctrl` itself.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs 0 and `busy`=0. `start` held high during reset is ignored.
- N=1 on all-zero state → `done` in cycle 2. After the S-box stage, x0=x1=x3=0x4b, x2=0xffffffffffffffb4, x4=0. Final `x4_out`=0. x0..x3 match the golden model.
- N=12, 8 and 6 on random states → `busy` high exactly N cycles, `done` in cycle N+1, output bit-exact to the C reference permutation. Also run `rounds`=0 and `rounds`=15, which must match N=12.
- Back-to-back: reassert `start` in the `done` cycle with a new state → second `done` arrives exactly N+1 cycles later. The first result is visible in the first `done` cycle.
- `start` pulsed in cycle 3 of an N=12 run with a different state → ignored. Result is unchanged and `done` stays in cycle 13.
- `rst` in cycle 5 of an N=12 run → outputs zero in cycle 6, no `done` through cycle 20, and a following `start` completes normally.
